// File: rtl/vga_pkg.sv
// Shared VGA timing constants and color helpers for the 640x480@60 Hz display path.
package vga_pkg;

    localparam int unsigned COLOR_W = 3;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;
    localparam int unsigned DEF_CLK_DIV   = 4;

    localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned DEF_HS_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int unsigned DEF_VS_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // Each color code bit drives a whole 4-bit channel fully on or off.
    function automatic logic [11:0] expand3to12(input logic [COLOR_W-1:0] c);
        return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate enable: one-clk tick every CLK_DIV system clocks, plus a marker for the
// first clk of each pixel.
module vga_pixel_tick
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic pix_start
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    always_comb begin
        tick      = (div_q == DIV_LAST);
        pix_start = (div_q == '0);
        div_d     = tick ? '0 : div_q + DW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/vga_display.sv
// VGA timing generator and pixel painter: scans h/v, latches the color once per frame
// and registers syncs, RGB and coordinates one clk behind the counters.
module vga_display
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COLOR_W-1:0] color,
    output logic               hsync,
    output logic               vsync,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               video_on,
    output logic               frame_start,
    output logic [9:0]         x,
    output logic [9:0]         y
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VISEND = 10'(H_VISIBLE);
    localparam logic [9:0] V_VISEND = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic tick;
    logic pix_start;

    vga_pixel_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .pix_start(pix_start)
    );

    logic [9:0]         h_q, h_d;
    logic [9:0]         v_q, v_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               frame_end;

    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        color_d   = color_q;
        frame_end = tick && (h_q == H_LAST) && (v_q == V_LAST);
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        // Sampling only at the frame boundary keeps each frame a single color.
        if (frame_end) begin
            color_d = color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            color_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            color_q <= color_d;
        end
    end

    logic        hs_active;
    logic        vs_active;
    logic        vis;
    logic        first_pix;
    logic [11:0] rgb;

    always_comb begin
        hs_active = (h_q >= HS_START) && (h_q < HS_END);
        vs_active = (v_q >= VS_START) && (v_q < VS_END);
        vis       = (h_q < H_VISEND) && (v_q < V_VISEND);
        first_pix = pix_start && (h_q == '0) && (v_q == '0);
        rgb       = vis ? expand3to12(color_q) : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else begin
            hsync       <= ~hs_active;
            vsync       <= ~vs_active;
            vga_r       <= rgb[11:8];
            vga_g       <= rgb[7:4];
            vga_b       <= rgb[3:0];
            video_on    <= vis;
            frame_start <= first_pix;
            x           <= h_q;
            y           <= v_q;
        end
    end

endmodule

// File: tb/tb_vga_display.sv
// Scoreboard bench for vga_display on a shrunken raster (15x8 pixels, 4 clks per pixel).
module tb_vga_display;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2, HT = 15;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1, VT = 8;
    localparam int DIV = 4;
    localparam int LINE_CLKS  = HT * DIV;     // 60
    localparam int FRAME_CLKS = LINE_CLKS * VT; // 480

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] color;
    logic       hsync, vsync, video_on, frame_start;
    logic [3:0] vga_r, vga_g, vga_b;
    logic [9:0] x, y;

    vga_display #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .color      (color),
        .hsync      (hsync),
        .vsync      (vsync),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .video_on   (video_on),
        .frame_start(frame_start),
        .x          (x),
        .y          (y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hs, vs, von, fs;
        logic [3:0] r, g, b;
        logic [9:0] x, y;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    int         k;
    logic [2:0] fcolor;

    // One system clk: the expected output after this edge is derived from the clk count
    // since reset release, independent of any counter chain.
    task automatic cyc();
        logic [2:0] smp;
        logic       r;
        exp_t       e;
        int         px, hh, vv;
        smp = color;
        r   = rst;
        @(posedge clk);
        #1;
        if (r) begin
            e = '{hs: 1'b1, vs: 1'b1, von: 1'b0, fs: 1'b0, r: 4'h0, g: 4'h0, b: 4'h0,
                  x: 10'd0, y: 10'd0};
            k      = 0;
            fcolor = 3'b000;
        end else begin
            px = k / DIV;
            hh = px % HT;
            vv = (px / HT) % VT;
            e.x   = 10'(hh);
            e.y   = 10'(vv);
            e.hs  = !(hh >= 10 && hh < 13);
            e.vs  = !(vv >= 5 && vv < 7);
            e.von = (hh < 8) && (vv < 4);
            e.fs  = (k % FRAME_CLKS) == 0;
            e.r   = (e.von && fcolor[2]) ? 4'hF : 4'h0;
            e.g   = (e.von && fcolor[1]) ? 4'hF : 4'h0;
            e.b   = (e.von && fcolor[0]) ? 4'hF : 4'h0;
            if (k % FRAME_CLKS == FRAME_CLKS - 1) fcolor = smp;
            k++;
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (hsync !== e.hs || vsync !== e.vs || video_on !== e.von ||
                frame_start !== e.fs || vga_r !== e.r || vga_g !== e.g ||
                vga_b !== e.b || x !== e.x || y !== e.y) begin
                n_fail++;
                $display("FAIL scan t=%0t got hs=%b vs=%b von=%b fs=%b rgb=%h%h%h x=%0d y=%0d want hs=%b vs=%b von=%b fs=%b rgb=%h%h%h x=%0d y=%0d",
                         $time, hsync, vsync, video_on, frame_start, vga_r, vga_g, vga_b,
                         x, y, e.hs, e.vs, e.von, e.fs, e.r, e.g, e.b, e.x, e.y);
            end
        end
    end

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Sync pulse period and width measured in clks against hand-computed figures.
    int   ncyc = 0;
    int   hf_t, vf_t;
    bit   hf_ok = 0, hl_ok = 0, vf_ok = 0, vl_ok = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            hf_ok = 0; hl_ok = 0; vf_ok = 0; vl_ok = 0;
        end else begin
            if (prev_hs === 1'b1 && hsync === 1'b0) begin
                if (hf_ok) check_int("hsync_period", ncyc - hf_t, 3 * 0 + 60);
                hf_ok = 1; hl_ok = 1; hf_t = ncyc;
            end
            if (prev_hs === 1'b0 && hsync === 1'b1 && hl_ok) begin
                check_int("hsync_low", ncyc - hf_t, 12);
                hl_ok = 0;
            end
            if (prev_vs === 1'b1 && vsync === 1'b0) begin
                if (vf_ok) check_int("vsync_period", ncyc - vf_t, 480);
                vf_ok = 1; vl_ok = 1; vf_t = ncyc;
            end
            if (prev_vs === 1'b0 && vsync === 1'b1 && vl_ok) begin
                check_int("vsync_low", ncyc - vf_t, 120);
                vl_ok = 0;
            end
        end
        prev_hs = hsync;
        prev_vs = vsync;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        k      = 0;
        fcolor = 3'b000;
        rst    = 1'b1;
        color  = 3'b000;
        repeat (10) cyc();
        // Frame 0 stays black (color_q cleared); 101 is sampled at its end.
        rst   = 1'b0;
        color = 3'b101;
        repeat (720) cyc();
        // Mid frame 1: green will be latched for frame 2.
        color = 3'b010;
        repeat (376) cyc();
        // Frame 2 at pixel (4,2): red request must not tear frame 2.
        color = 3'b100;
        repeat (823) cyc();
        // Change lands on the sampling edge itself, so cyan wins for frame 4.
        color = 3'b011;
        repeat (141) cyc();
        // Reset at pixel (5,2) of frame 4 for 3 clks.
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (600) cyc();
        @(negedge clk);
        @(negedge clk);
        check_int("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
